// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a FIFO head word: start bit, WIDTH data bits LSB first,
// optional even parity (enabled by defining UART_PARITY_EN), one stop bit.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_shift_out,
    output logic             txd,
    output logic             busy
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               txd_q, txd_d;
    logic               baud_last;
    logic               pop;
`ifdef UART_PARITY_EN
    logic               par_q, par_d;
`endif

    assign baud_last = (baud_q == BaudLast);

    // A new word may be taken from idle or on the final stop cycle (zero-gap back-to-back).
    assign pop = enable & ~fifo_empty & ~res &
                 ((state_q == StIdle) | ((state_q == StStop) & baud_last));

    assign fifo_shift_out = pop;
    assign busy           = (state_q != StIdle);
    assign txd            = txd_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != StIdle) begin
            baud_d = baud_last ? '0 : baud_q + BaudW'(1);
        end

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (baud_last) state_d = StData;
            end
            StData: begin
                if (baud_last) begin
                    sr_d  = sr_q >> 1;
                    bit_d = bit_q + BitW'(1);
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (baud_last) state_d = StStop;
            end
`endif
            StStop: begin
                if (baud_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            state_d = StStart;
            baud_d  = '0;
            bit_d   = '0;
            sr_d    = fifo_rdata;
`ifdef UART_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
        end

        // Line level is registered from the next state so the pin is glitch-free.
        unique case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = sr_d[0];
`ifdef UART_PARITY_EN
            StParity: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            txd_q   <= txd_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, scoreboard of pushed words, serial-line frame monitor.
module tb_fifo_uart_tx;

    localparam int unsigned W   = 8;
    localparam int unsigned CPB = 4;
`ifdef UART_PARITY_EN
    localparam int unsigned NB = W + 3;
`else
    localparam int unsigned NB = W + 2;
`endif
    localparam int unsigned FRAME = NB * CPB;

    logic         clk;
    logic         res;
    logic         enable;
    logic [W-1:0] fifo_rdata = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_shift_out;
    logic         txd;
    logic         busy;

    logic [W-1:0] fifo1_rdata = '0;
    logic         fifo1_empty = 1'b1;
    logic         fifo1_shift_out;
    logic         txd1;
    logic         busy1;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cyc    = 0;
    int last_gap   = 0;
    int prev_start = -1;
    int abort_cnt  = 0;
    int abort_seen = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic         bit_q[$];

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
        .clk            (clk),
        .res            (res),
        .enable         (enable),
        .fifo_rdata     (fifo_rdata),
        .fifo_empty     (fifo_empty),
        .fifo_shift_out (fifo_shift_out),
        .txd            (txd),
        .busy           (busy)
    );

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut_fast (
        .clk            (clk),
        .res            (res),
        .enable         (enable),
        .fifo_rdata     (fifo1_rdata),
        .fifo_empty     (fifo1_empty),
        .fifo_shift_out (fifo1_shift_out),
        .txd            (txd1),
        .busy           (busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic run_until_idle(input int max, output int busy_cyc);
        bit seen = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                seen = 1'b1;
                busy_cyc++;
            end else if (seen) begin
                return;
            end
        end
        check_val("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (busy === 1'b1) return;
        end
        check_val("busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // FIFO model: pop on the strobe edge, head/flag presented from the following negedge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_shift_out === 1'b1) begin
            pops <= pops + 1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
    end

    always @(negedge clk) begin
        fifo_empty <= (fifo_q.size() == 0);
        fifo_rdata <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // Frame monitor: every bit must be constant for CPB cycles with busy high.
    initial begin
        logic [NB-1:0] bv;
        logic [W-1:0]  exp_w;
        bit            unstable;
        bit            aborted;
        int            start;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                start    = cyc;
                unstable = 1'b0;
                aborted  = 1'b0;
                bv       = '0;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_frame", 32'd1, 32'd0);
                    exp_w = '0;
                end else begin
                    exp_w = exp_q.pop_front();
                end
                for (int b = 0; b < int'(NB); b++) begin
                    for (int c = 0; c < int'(CPB); c++) begin
                        if (!aborted) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (abort_cnt != abort_seen) begin
                                abort_seen = abort_cnt;
                                aborted    = 1'b1;
                            end else begin
                                if (c == 0) bv[b] = txd;
                                else if (txd !== bv[b]) unstable = 1'b1;
                                if (busy !== 1'b1) unstable = 1'b1;
                            end
                        end
                    end
                end
                if (!aborted) begin
                    check_val("frame_data", 32'(bv[W:1]), 32'(exp_w));
`ifdef UART_PARITY_EN
                    check_val("frame_parity", 32'(bv[W+1]), 32'(^exp_w));
`endif
                    check_val("frame_stop", 32'(bv[NB-1]), 32'd1);
                    check_val("frame_stable", 32'(unstable), 32'd0);
                    if (prev_start >= 0) last_gap = start - prev_start;
                    prev_start = start;
                end
            end
        end
    end

    initial begin
        int           p0;
        int           bc;
        bit           found;
        bit           any_pop;
        bit           any_low;
        bit           any_busy;
        logic [W-1:0] w1;

        res    = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        push(8'hA5);
        repeat (2) @(negedge clk);
        check_val("reset_no_pop", 32'(fifo_shift_out), 32'd0);
        check_val("reset_txd", 32'(txd), 32'd1);
        check_val("reset_busy", 32'(busy), 32'd0);
        p0  = pops;
        res = 1'b0;
        run_until_idle(400, bc);
        check_val("single_busy_len", 32'(bc), 32'(FRAME));
        check_val("single_pops", 32'(pops - p0), 32'd1);
        check_val("single_idle_txd", 32'(txd), 32'd1);

        // Back-to-back frames with zero gap.
        p0 = pops;
        push(8'hA5);
        push(8'h01);
        run_until_idle(800, bc);
        check_val("b2b_busy_len", 32'(bc), 32'(2 * FRAME));
        check_val("b2b_pops", 32'(pops - p0), 32'd2);
        check_val("b2b_gap", 32'(last_gap), 32'(FRAME));

        // Empty FIFO stays idle.
        any_pop  = 1'b0;
        any_low  = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_shift_out !== 1'b0) any_pop = 1'b1;
            if (txd !== 1'b1) any_low = 1'b1;
            if (busy !== 1'b0) any_busy = 1'b1;
        end
        check_val("empty_no_pop", 32'(any_pop), 32'd0);
        check_val("empty_txd_high", 32'(any_low), 32'd0);
        check_val("empty_not_busy", 32'(any_busy), 32'd0);

        // Enable dropped mid-frame: frame finishes, queued word waits.
        p0 = pops;
        push(8'hFF);
        push(8'h33);
        wait_busy(50);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        run_until_idle(200, bc);
        check_val("en_low_one_pop", 32'(pops - p0), 32'd1);
        repeat (20) @(negedge clk);
        check_val("en_low_held", 32'(pops - p0), 32'd1);
        check_val("en_low_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        run_until_idle(200, bc);
        check_val("en_resume_pops", 32'(pops - p0), 32'd2);

        // Reset during data bit 3 discards the popped word.
        p0 = pops;
        push(8'h5A);
        push(8'hC3);
        wait_busy(50);
        repeat (17) @(negedge clk);
        abort_cnt = abort_cnt + 1;
        res       = 1'b1;
        @(negedge clk);
        check_val("midres_no_pop", 32'(fifo_shift_out), 32'd0);
        check_val("midres_txd", 32'(txd), 32'd1);
        check_val("midres_busy", 32'(busy), 32'd0);
        check_val("midres_pops", 32'(pops - p0), 32'd1);
        res = 1'b0;
        run_until_idle(200, bc);
        check_val("midres_after_pops", 32'(pops - p0), 32'd2);
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // One clock per bit.
        w1 = 8'h3C;
        bit_q.push_back(1'b0);
        for (int i = 0; i < int'(W); i++) bit_q.push_back(w1[i]);
`ifdef UART_PARITY_EN
        bit_q.push_back(^w1);
`endif
        bit_q.push_back(1'b1);
        fifo1_rdata = w1;
        fifo1_empty = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo1_shift_out === 1'b1) found = 1'b1;
        end
        check_val("cpb1_pop_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 fifo1_empty = 1'b1;
        while (bit_q.size() != 0) begin
            @(negedge clk);
            check_val("cpb1_bit", 32'(txd1), 32'(bit_q.pop_front()));
        end
        @(negedge clk);
        check_val("cpb1_idle_busy", 32'(busy1), 32'd0);
        check_val("cpb1_idle_txd", 32'(txd1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
